// File: rtl/mem_responder.sv
// mem_responder: single-ported 16-bit word store shared by an instruction-side
// read port and a data-side read/write port. One transaction is in flight at a
// time; the data side wins arbitration. The response (valid pulse, and read
// data for reads) appears exactly LATENCY cycles after the accepting cycle.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic        i_valid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  LAST  = 4'(LATENCY - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic                tag_d_r;
    logic                wr_r;
    logic [ADDR_W-1:0]   idx_r;
    logic                i_valid_r;
    logic                d_valid_r;
    logic [15:0]         i_rdata_r;
    logic [15:0]         d_rdata_r;
    logic [15:0]         mem [0:DEPTH-1];

    logic                open_s;
    logic                d_ack_s;
    logic                i_ack_s;
    logic                resp_entry_s;
    logic [ADDR_W-1:0]   d_idx_s;
    logic [ADDR_W-1:0]   i_idx_s;
    logic [31:0]         unused_addr_s;

    // Byte address bit 0 and bits above the word index are deliberately ignored.
    assign unused_addr_s = {i_addr, d_addr};
    assign d_idx_s       = d_addr[ADDR_W:1];
    assign i_idx_s       = i_addr[ADDR_W:1];

    // Acks are combinational so a held request is taken in the same cycle;
    // they are gated by rst_n so reset silences them immediately.
    assign open_s       = rst_n && ((state_r == IDLE) || (state_r == RESP));
    assign d_ack_s      = open_s && d_req;
    assign i_ack_s      = open_s && i_req && !d_req;
    assign resp_entry_s = (state_r == WAIT) && (cnt_r == LAST);

    assign d_ack   = d_ack_s;
    assign i_ack   = i_ack_s;
    assign d_valid = d_valid_r;
    assign i_valid = i_valid_r;
    assign d_rdata = d_rdata_r;
    assign i_rdata = i_rdata_r;
    assign busy    = (state_r != IDLE);

    // Next-state and latency counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (d_ack_s || i_ack_s) begin
                    state_next_s = WAIT;
                    cnt_next_s   = 4'd1;
                end else begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt_r == LAST) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
                cnt_next_s = cnt_r + 4'd1;
            end
            RESP: begin
                if (d_ack_s || i_ack_s) begin
                    state_next_s = WAIT;
                    cnt_next_s   = 4'd1;
                end else begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture port tag, direction and word index of the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_d_r <= 1'b0;
            wr_r    <= 1'b0;
            idx_r   <= '0;
        end else if (d_ack_s) begin
            tag_d_r <= 1'b1;
            wr_r    <= d_wr;
            idx_r   <= d_idx_s;
        end else if (i_ack_s) begin
            tag_d_r <= 1'b0;
            wr_r    <= 1'b0;
            idx_r   <= i_idx_s;
        end
    end

    // Writes commit at the acceptance edge; storage is never cleared.
    always_ff @(posedge clk) begin
        if (d_ack_s && d_wr) begin
            mem[d_idx_s] <= d_wdata;
        end
    end

    // Response registers: one-cycle valid for the granted port, read data
    // loaded on entry to RESP and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid_r <= 1'b0;
            d_valid_r <= 1'b0;
            i_rdata_r <= 16'h0000;
            d_rdata_r <= 16'h0000;
        end else begin
            i_valid_r <= resp_entry_s && !tag_d_r;
            d_valid_r <= resp_entry_s && tag_d_r;
            if (resp_entry_s && !wr_r) begin
                if (tag_d_r) begin
                    d_rdata_r <= mem[idx_r];
                end else begin
                    i_rdata_r <= mem[idx_r];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default build (LATENCY=4, ADDR_W=15)
// and a small build (LATENCY=2, ADDR_W=4) share clock and reset.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build signals
    logic        i_req, i_ack, i_valid, d_req, d_wr, d_ack, d_valid, busy;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    // Small build signals
    logic        b_i_req, b_i_ack, b_i_valid, b_d_req, b_d_wr, b_d_ack, b_d_valid, b_busy;
    logic [15:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;

    mem_responder #(.LATENCY(4), .ADDR_W(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_valid(d_valid), .d_rdata(d_rdata), .busy(busy)
    );

    mem_responder #(.LATENCY(2), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_valid(b_i_valid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_valid(b_d_valid), .d_rdata(b_d_rdata), .busy(b_busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        d_req = 1'b1; i_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000; i_addr = 16'h0000;
        b_d_req = 1'b1; b_i_req = 1'b0; b_d_wr = 1'b0; b_d_addr = 16'h0000; b_d_wdata = 16'h0000; b_i_addr = 16'h0000;
        @(negedge clk);
        checks++;
        if ({d_ack, i_ack, d_valid, i_valid, busy} !== 5'b00000) begin
            errors++; $display("FAIL reset ctrl: got %b want 00000", {d_ack, i_ack, d_valid, i_valid, busy});
        end
        checks++;
        if ({d_rdata, i_rdata} !== 32'h0000_0000) begin
            errors++; $display("FAIL reset rdata: got %h want 00000000", {d_rdata, i_rdata});
        end
        checks++;
        if ({b_d_ack, b_busy, b_d_valid} !== 3'b000) begin
            errors++; $display("FAIL reset small ctrl: got %b want 000", {b_d_ack, b_busy, b_d_valid});
        end
        d_req = 1'b0; i_req = 1'b0; b_d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // D write BEEF to 0x0010 at cycle 0, D read of it at cycle 5.
    task automatic test_write_read();
        for (int c = 0; c <= 10; c++) begin
            d_req = (c == 0 || c == 5); d_wr = (c == 0);
            d_addr = 16'h0010; d_wdata = (c == 0) ? 16'hBEEF : 16'h0000;
            @(negedge clk);
            checks++;
            if (d_ack !== (c == 0 || c == 5)) begin
                errors++; $display("FAIL wr_rd d_ack c%0d: got %b want %b", c, d_ack, (c == 0 || c == 5));
            end
            checks++;
            if (d_valid !== (c == 4 || c == 9)) begin
                errors++; $display("FAIL wr_rd d_valid c%0d: got %b want %b", c, d_valid, (c == 4 || c == 9));
            end
            checks++;
            if (busy !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin
                errors++; $display("FAIL wr_rd busy c%0d: got %b", c, busy);
            end
            checks++;
            if (i_valid !== 1'b0) begin
                errors++; $display("FAIL wr_rd i_valid c%0d: got %b want 0", c, i_valid);
            end
            if (c == 4) begin
                checks++;
                if (d_rdata !== 16'h0000) begin
                    errors++; $display("FAIL wr_rd write_rdata c%0d: got %h want 0000", c, d_rdata);
                end
            end
            if (c == 9 || c == 10) begin
                checks++;
                if (d_rdata !== 16'hBEEF) begin
                    errors++; $display("FAIL wr_rd read_rdata c%0d: got %h want beef", c, d_rdata);
                end
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0;
    endtask

    // Both ports request at cycle 0: D write A5A5 to 0x0030, I read 0x0010.
    task automatic test_arbitration();
        for (int c = 0; c <= 10; c++) begin
            d_req = (c == 0); d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hA5A5;
            i_req = (c <= 4); i_addr = 16'h0010;
            @(negedge clk);
            checks++;
            if (d_ack !== (c == 0)) begin
                errors++; $display("FAIL arb d_ack c%0d: got %b want %b", c, d_ack, (c == 0));
            end
            checks++;
            if (i_ack !== (c == 4)) begin
                errors++; $display("FAIL arb i_ack c%0d: got %b want %b", c, i_ack, (c == 4));
            end
            checks++;
            if (d_valid !== (c == 4)) begin
                errors++; $display("FAIL arb d_valid c%0d: got %b want %b", c, d_valid, (c == 4));
            end
            checks++;
            if (i_valid !== (c == 8)) begin
                errors++; $display("FAIL arb i_valid c%0d: got %b want %b", c, i_valid, (c == 8));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 8)) begin
                errors++; $display("FAIL arb busy c%0d: got %b want %b", c, busy, (c >= 1 && c <= 8));
            end
            if (c == 4) begin
                checks++;
                if (d_rdata !== 16'hBEEF) begin
                    errors++; $display("FAIL arb write_keeps_rdata: got %h want beef", d_rdata);
                end
            end
            if (c == 7 || c == 8) begin
                checks++;
                if (i_rdata !== ((c == 8) ? 16'hBEEF : 16'h0000)) begin
                    errors++; $display("FAIL arb i_rdata c%0d: got %h", c, i_rdata);
                end
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0; i_req = 1'b0; d_wr = 1'b0;
    endtask

    // D read held continuously; address changes after each ack.
    task automatic test_back_to_back();
        for (int c = 0; c <= 13; c++) begin
            d_req = (c <= 8); d_wr = 1'b0;
            d_addr = (c <= 3) ? 16'h0031 : (c <= 7) ? 16'h0010 : 16'h0030;
            @(negedge clk);
            checks++;
            if (d_ack !== (c == 0 || c == 4 || c == 8)) begin
                errors++; $display("FAIL b2b d_ack c%0d: got %b", c, d_ack);
            end
            checks++;
            if (d_valid !== (c == 4 || c == 8 || c == 12)) begin
                errors++; $display("FAIL b2b d_valid c%0d: got %b", c, d_valid);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 12)) begin
                errors++; $display("FAIL b2b busy c%0d: got %b", c, busy);
            end
            if (c == 4 || c == 8 || c == 12) begin
                checks++;
                if (d_rdata !== ((c == 8) ? 16'hBEEF : 16'hA5A5)) begin
                    errors++; $display("FAIL b2b d_rdata c%0d: got %h want %h", c, d_rdata,
                                       (c == 8) ? 16'hBEEF : 16'hA5A5);
                end
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0;
    endtask

    // Reset in cycle 2 of a read; next read accepted in first IDLE cycle after.
    task automatic test_reset_mid();
        for (int c = 0; c <= 10; c++) begin
            rst_n = !(c == 2 || c == 3);
            d_req = (c == 0 || c == 4); d_wr = 1'b0;
            d_addr = (c == 0) ? 16'h0031 : 16'h0010;
            if (c == 2) #1;
            @(negedge clk);
            checks++;
            if (d_ack !== (c == 0 || c == 4)) begin
                errors++; $display("FAIL rst_mid d_ack c%0d: got %b", c, d_ack);
            end
            checks++;
            if (d_valid !== (c == 8)) begin
                errors++; $display("FAIL rst_mid d_valid c%0d: got %b want %b", c, d_valid, (c == 8));
            end
            checks++;
            if (busy !== (c == 1 || (c >= 5 && c <= 8))) begin
                errors++; $display("FAIL rst_mid busy c%0d: got %b", c, busy);
            end
            if (c == 2 || c == 8) begin
                checks++;
                if ({d_rdata, i_rdata} !== ((c == 8) ? 32'hBEEF_0000 : 32'h0000_0000)) begin
                    errors++; $display("FAIL rst_mid rdata c%0d: got %h", c, {d_rdata, i_rdata});
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1; d_req = 1'b0;
    endtask

    // Small build: write 0x0022 then read 0x0002 hits the same word.
    task automatic test_wrap();
        for (int c = 0; c <= 6; c++) begin
            b_d_req = (c == 0 || c == 3); b_d_wr = (c == 0);
            b_d_addr = (c == 0) ? 16'h0022 : 16'h0002; b_d_wdata = 16'h5A3C;
            @(negedge clk);
            checks++;
            if (b_d_valid !== (c == 2 || c == 5)) begin
                errors++; $display("FAIL wrap d_valid c%0d: got %b", c, b_d_valid);
            end
            if (c == 5) begin
                checks++;
                if (b_d_rdata !== 16'h5A3C) begin
                    errors++; $display("FAIL wrap d_rdata: got %h want 5a3c", b_d_rdata);
                end
            end
            @(posedge clk); #1;
        end
        b_d_req = 1'b0; b_d_wr = 1'b0;
    endtask

    // Small build: i_req arriving in WAIT is acked only in RESP.
    task automatic test_latency2();
        for (int c = 0; c <= 6; c++) begin
            b_d_req = (c == 0); b_d_addr = 16'h0002;
            b_i_req = (c == 1 || c == 2); b_i_addr = 16'h0022;
            @(negedge clk);
            checks++;
            if (b_i_ack !== (c == 2)) begin
                errors++; $display("FAIL lat2 i_ack c%0d: got %b want %b", c, b_i_ack, (c == 2));
            end
            checks++;
            if (b_d_valid !== (c == 2)) begin
                errors++; $display("FAIL lat2 d_valid c%0d: got %b want %b", c, b_d_valid, (c == 2));
            end
            checks++;
            if (b_i_valid !== (c == 4)) begin
                errors++; $display("FAIL lat2 i_valid c%0d: got %b want %b", c, b_i_valid, (c == 4));
            end
            checks++;
            if (b_busy !== (c >= 1 && c <= 4)) begin
                errors++; $display("FAIL lat2 busy c%0d: got %b", c, b_busy);
            end
            if (c == 4) begin
                checks++;
                if (b_i_rdata !== 16'h5A3C) begin
                    errors++; $display("FAIL lat2 i_rdata: got %h want 5a3c", b_i_rdata);
                end
            end
            @(posedge clk); #1;
        end
        b_d_req = 1'b0; b_i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_wrap();
        test_latency2();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
